// File: rtl/iob_plic_claim_agent.sv
// Hardware claim/complete sequencer for one PLIC target: reads the claim register,
// hands the claimed ID to the handler, then writes it back to complete the interrupt.
module iob_plic_claim_agent #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 6,
    parameter int CLAIM_ADDR = 0,
    parameter int HOLDOFF    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  irq_i,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    output logic                  vec_valid_o,
    output logic [ID_W-1:0]       vec_id_o,
    input  logic                  vec_ack_i,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      spurious_cnt_o
);

    localparam int               STRB_W    = DATA_W / 8;
    localparam logic [3:0]       HOLD_INIT = 4'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_PRESENT,
        S_WR_REQ
    } state_t;

    state_t              state_q;
    logic [3:0]          holdoff_q;
    logic                avalid_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                vec_valid_q;
    logic [ID_W-1:0]     vec_id_q;
    logic [CNT_W-1:0]    spur_cnt_q;
    logic [CNT_W-1:0]    spur_cnt_d;
    logic [ID_W-1:0]     rd_id;
    logic                unused_rdata_hi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Only the low ID_W bits of the claim register carry the source ID.
    assign rd_id           = iob_rdata_i[ID_W-1:0];
    assign unused_rdata_hi = ^iob_rdata_i[DATA_W-1:ID_W];
    assign spur_cnt_d      = sat_inc(spur_cnt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            holdoff_q   <= 4'd0;
            avalid_q    <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            spur_cnt_q  <= '0;
        end else if (cke_i) begin
            case (state_q)
                S_IDLE: begin
                    // Holdoff masks the PLIC's stale irq right after a completion.
                    if (holdoff_q != 4'd0) begin
                        holdoff_q <= holdoff_q - 4'd1;
                    end else if (en_i && irq_i) begin
                        avalid_q <= 1'b1;
                        wstrb_q  <= '0;
                        state_q  <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (iob_ready_i) begin
                        avalid_q <= 1'b0;
                        state_q  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (iob_rvalid_i) begin
                        if (rd_id == '0) begin
                            spur_cnt_q <= spur_cnt_d;
                            holdoff_q  <= HOLD_INIT;
                            state_q    <= S_IDLE;
                        end else begin
                            vec_valid_q <= 1'b1;
                            vec_id_q    <= rd_id;
                            state_q     <= S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    if (vec_ack_i) begin
                        vec_valid_q <= 1'b0;
                        avalid_q    <= 1'b1;
                        wstrb_q     <= '1;
                        wdata_q     <= DATA_W'(vec_id_q);
                        state_q     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (iob_ready_i) begin
                        avalid_q  <= 1'b0;
                        wstrb_q   <= '0;
                        wdata_q   <= '0;
                        vec_id_q  <= '0;
                        holdoff_q <= HOLD_INIT;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign iob_avalid_o   = avalid_q;
    assign iob_addr_o     = ADDR_W'(CLAIM_ADDR);
    assign iob_wdata_o    = wdata_q;
    assign iob_wstrb_o    = wstrb_q;
    assign vec_valid_o    = vec_valid_q;
    assign vec_id_o       = vec_id_q;
    assign busy_o         = (state_q != S_IDLE);
    assign spurious_cnt_o = spur_cnt_q;

endmodule

// File: tb/tb_iob_plic_claim_agent.sv
// Bench for iob_plic_claim_agent: emulates the PLIC claim register as an IOb slave
// and checks every cycle against a transaction-level model plus directed literals.
module tb_iob_plic_claim_agent;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int ID_W       = 6;
    localparam int CNT_W      = 2;
    localparam int HOLDOFF    = 2;
    localparam int CLAIM_ADDR = 'h0204;
    localparam logic [31:0] RD_UPPER = 32'hA5A5_5AC0;

    logic              clk = 1'b0;
    logic              cke_i, rst_i, en_i, irq_i;
    logic              iob_avalid_o;
    logic [ADDR_W-1:0] iob_addr_o;
    logic [DATA_W-1:0] iob_wdata_o;
    logic [3:0]        iob_wstrb_o;
    logic              iob_ready_i, iob_rvalid_i;
    logic [DATA_W-1:0] iob_rdata_i;
    logic              vec_valid_o;
    logic [ID_W-1:0]   vec_id_o;
    logic              vec_ack_i;
    logic              busy_o;
    logic [CNT_W-1:0]  spurious_cnt_o;

    always #5 clk = ~clk;

    iob_plic_claim_agent #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .CLAIM_ADDR(CLAIM_ADDR), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i), .en_i(en_i), .irq_i(irq_i),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
        .vec_valid_o(vec_valid_o), .vec_id_o(vec_id_o), .vec_ack_i(vec_ack_i),
        .busy_o(busy_o), .spurious_cnt_o(spurious_cnt_o)
    );

    int total = 0;
    int bad = 0;
    int vec_cnt = 0;
    int rv_extra = 0;
    logic [5:0] idq [0:63];
    int wr_i = 0;
    int rd_i = 0;

    // Model: one flag per phase of a claim transaction, advanced from the rules.
    bit   m_rd = 0, m_wait = 0, m_pres = 0, m_wr = 0;
    int   m_hold = 0;
    int   m_cnt = 0;
    logic [5:0] m_id = '0;
    int   n_rd = 0, n_wr = 0;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) begin
        if (!rst_i && cke_i && iob_avalid_o && iob_ready_i) begin
            if (iob_wstrb_o == 4'h0) n_rd <= n_rd + 1;
            else begin
                n_wr <= n_wr + 1;
                last_wdata <= iob_wdata_o;
            end
        end
        if (rst_i) begin
            m_rd <= 0; m_wait <= 0; m_pres <= 0; m_wr <= 0;
            m_hold <= 0; m_cnt <= 0; m_id <= '0;
        end else if (cke_i) begin
            if (m_rd) begin
                if (iob_ready_i) begin m_rd <= 0; m_wait <= 1; end
            end else if (m_wait) begin
                if (iob_rvalid_i) begin
                    m_wait <= 0;
                    if (iob_rdata_i[5:0] == 6'd0) begin
                        m_cnt  <= (m_cnt < 3) ? m_cnt + 1 : m_cnt;
                        m_hold <= HOLDOFF;
                    end else begin
                        m_pres <= 1;
                        m_id   <= iob_rdata_i[5:0];
                    end
                end
            end else if (m_pres) begin
                if (vec_ack_i) begin m_pres <= 0; m_wr <= 1; end
            end else if (m_wr) begin
                if (iob_ready_i) begin m_wr <= 0; m_id <= '0; m_hold <= HOLDOFF; end
            end else if (m_hold > 0) begin
                m_hold <= m_hold - 1;
            end else if (en_i && irq_i) begin
                m_rd <= 1;
            end
        end
    end

    // PLIC claim register emulation: answers each accepted read with the next queued ID.
    initial begin
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = '0;
        forever begin
            @(posedge clk);
            if (!rst_i && cke_i && iob_avalid_o && iob_ready_i && iob_wstrb_o == 4'h0) begin
                repeat (rv_extra) @(posedge clk);
                #1;
                iob_rvalid_i = 1'b1;
                if (rd_i < wr_i) begin
                    iob_rdata_i = RD_UPPER | {26'd0, idq[rd_i[5:0]]};
                    rd_i++;
                end else begin
                    iob_rdata_i = RD_UPPER;
                end
                @(posedge clk);
                #1;
                iob_rvalid_i = 1'b0;
                iob_rdata_i  = '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        logic [62:0] act, exp;
        act = {iob_avalid_o, iob_wstrb_o, iob_wdata_o, vec_valid_o, vec_id_o,
               busy_o, spurious_cnt_o, iob_addr_o};
        exp = {m_rd | m_wr, (m_wr ? 4'hF : 4'h0), (m_wr ? {26'd0, m_id} : 32'd0),
               m_pres, m_id, (m_rd | m_wait | m_pres | m_wr), 2'(m_cnt), 16'(CLAIM_ADDR)};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_model at %0t: dut=%h model=%h", $time, act, exp);
        end
        if (vec_valid_o) vec_cnt++;
    endtask

    task automatic push(input logic [5:0] id);
        idq[wr_i[5:0]] = id;
        wr_i++;
    endtask

    task automatic wait_ev(input int kind, input int target, input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            case (kind)
                0: ok = vec_valid_o;
                1: ok = (n_rd >= target);
                2: ok = (n_wr >= target);
                3: ok = !busy_o;
                default: ok = iob_avalid_o;
            endcase
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: event not seen within 100 cycles", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, vc0;
        logic [52:0] snap;
        rst_i = 1; cke_i = 1; en_i = 0; irq_i = 0;
        iob_ready_i = 1; vec_ack_i = 0;
        @(posedge clk); #1;
        fork
            forever begin
                @(negedge clk);
                cmp_cycle();
            end
        join_none
        @(negedge clk);
        chk("rst_avalid", iob_avalid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_vec_valid", vec_valid_o, 0);
        chk("rst_cnt", spurious_cnt_o, 0);
        chk("rst_wstrb", iob_wstrb_o, 0);
        @(posedge clk); #1;
        rst_i = 0;

        // Basic claim/complete with cycle-exact latency.
        en_i = 1; irq_i = 1; push(6'd5);
        @(negedge clk); chk("lat_c0_avalid", iob_avalid_o, 0);
        @(negedge clk); chk("rd_avalid", iob_avalid_o, 1);
        chk("rd_wstrb", iob_wstrb_o, 0);
        chk("rd_addr", iob_addr_o, CLAIM_ADDR);
        @(negedge clk); chk("lat_c2_vec", vec_valid_o, 0);
        irq_i = 0;
        @(negedge clk); chk("lat_c3_vec", vec_valid_o, 1);
        chk("vec_id5", vec_id_o, 5);
        vec_ack_i = 1;
        @(negedge clk); vec_ack_i = 0;
        chk("wr_avalid", iob_avalid_o, 1);
        chk("wr_wstrb", iob_wstrb_o, 4'hF);
        chk("wr_wdata", iob_wdata_o, 5);
        irq_i = 1; push(6'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("holdoff_quiet", iob_avalid_o, 0);
        end
        @(negedge clk); chk("holdoff_release", iob_avalid_o, 1);
        irq_i = 0;
        wait_ev(1, 2, "basic_second_read");
        wait_ev(3, 0, "basic_drain");
        chk("spur_first", spurious_cnt_o, 1);
        repeat (4) @(negedge clk);

        // Backpressure on both requests.
        iob_ready_i = 0; push(6'd9); irq_i = 1;
        wait_ev(4, 0, "bp_rd_start");
        r0 = n_rd;
        snap = {iob_avalid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rd_stable", {iob_avalid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o}, snap);
        end
        iob_ready_i = 1; irq_i = 0;
        @(negedge clk); iob_ready_i = 0;
        chk("bp_rd_one_accept", n_rd, r0 + 1);
        wait_ev(0, 0, "bp_vec");
        chk("bp_vec_id", vec_id_o, 9);
        w0 = n_wr;
        vec_ack_i = 1;
        @(negedge clk); vec_ack_i = 0;
        snap = {iob_avalid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o};
        chk("bp_wr_data", iob_wdata_o, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_wr_stable", {iob_avalid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o}, snap);
        end
        iob_ready_i = 1;
        @(negedge clk); iob_ready_i = 0;
        chk("bp_wr_one_accept", n_wr, w0 + 1);
        chk("bp_wr_logged", last_wdata, 9);
        iob_ready_i = 1;
        wait_ev(3, 0, "bp_drain");
        repeat (4) @(negedge clk);

        // Spurious claims and counter saturation (CNT_W=2 saturates at 3).
        rst_i = 1;
        @(negedge clk); rst_i = 0;
        chk("spur_rst_cnt", spurious_cnt_o, 0);
        vc0 = vec_cnt; w0 = n_wr; r0 = n_rd;
        for (int i = 0; i < 4; i++) push(6'd0);
        irq_i = 1;
        wait_ev(1, r0 + 3, "spur_three_reads");
        @(negedge clk); chk("spur_cnt3", spurious_cnt_o, 3);
        wait_ev(1, r0 + 4, "spur_fourth_read");
        irq_i = 0;
        @(negedge clk); @(negedge clk);
        chk("spur_saturate", spurious_cnt_o, 3);
        chk("spur_no_write", n_wr, w0);
        chk("spur_no_vec", vec_cnt, vc0);
        wait_ev(3, 0, "spur_drain");
        repeat (4) @(negedge clk);

        // Enable gating.
        en_i = 0; irq_i = 1; r0 = n_rd;
        repeat (10) @(negedge clk);
        chk("en0_no_read", n_rd, r0);
        chk("en0_idle", busy_o, 0);
        en_i = 1; push(6'd7);
        wait_ev(0, 0, "en_vec");
        chk("en_vec_id7", vec_id_o, 7);
        en_i = 0; w0 = n_wr;
        vec_ack_i = 1;
        @(negedge clk); vec_ack_i = 0;
        wait_ev(2, w0 + 1, "en_write");
        chk("en_wdata7", last_wdata, 7);
        repeat (10) @(negedge clk);
        chk("en_off_no_reclaim", n_rd, r0 + 1);
        chk("en_off_idle", busy_o, 0);
        irq_i = 0;

        // Reset during RD_WAIT with a late rvalid.
        rv_extra = 3; en_i = 1; irq_i = 1; push(6'd3); r0 = n_rd;
        wait_ev(1, r0 + 1, "rst_read");
        irq_i = 0; en_i = 0; rst_i = 1;
        @(negedge clk);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_avalid", iob_avalid_o, 0);
        chk("rstmid_vec", {vec_valid_o, vec_id_o}, 0);
        rst_i = 0;
        vc0 = vec_cnt;
        repeat (6) @(negedge clk);
        chk("rstmid_late_rvalid", vec_cnt, vc0);
        chk("rstmid_still_idle", busy_o, 0);
        rv_extra = 0;

        // Clock enable low while presenting, then while in holdoff.
        en_i = 1; irq_i = 1; push(6'd12);
        wait_ev(0, 0, "cke_vec");
        irq_i = 0; cke_i = 0; vec_ack_i = 1; w0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("cke_frozen", {vec_valid_o, vec_id_o, busy_o, iob_avalid_o}, {1'b1, 6'd12, 1'b1, 1'b0});
        end
        cke_i = 1;
        @(negedge clk); vec_ack_i = 0;
        chk("cke_wr_avalid", iob_avalid_o, 1);
        chk("cke_wr_wdata", iob_wdata_o, 12);
        wait_ev(2, w0 + 1, "cke_write");
        cke_i = 0; irq_i = 1; push(6'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("cke_hold_frozen", iob_avalid_o, 0);
        end
        cke_i = 1;
        @(negedge clk); chk("cke_hold_a", iob_avalid_o, 0);
        @(negedge clk); chk("cke_hold_b", iob_avalid_o, 0);
        @(negedge clk); chk("cke_hold_release", iob_avalid_o, 1);
        irq_i = 0;
        wait_ev(3, 0, "final_drain");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
